core_regfile_mp: RTL
====================

Name: core_regfile_mp

Overview:
- Parametrised multi-port successor to the 2-read/1-write core register file.
- Configurable register count, data width, read-port count and write-port count.
- Registered (1-cycle) reads with write-to-read bypass; x0 hardwired to zero.
- Per-register busy scoreboard, so issue logic can detect pending writebacks.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NRD, 2, number of read ports (>=1).
- NWR, 1, number of write ports (>=1).
- AW, $clog2(NREGS), address width; localparam, not overridable.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rs_re_i  in  NRD  per-port read enable.
- rs_addr_i  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW].
- rs_data_o  out  NRD*XLEN  read data, registered; port p occupies bits [p*XLEN +: XLEN].
- rs_busy_o  out  NRD  registered busy flag of the register read on port p.
- rd_we_i  in  NWR  per-port write enable.
- rd_addr_i  in  NWR*AW  write addresses.
- rd_data_i  in  NWR*XLEN  write data.
- rsv_we_i  in  1  reserve: mark register rsv_addr_i busy.
- rsv_addr_i  in  AW  register to reserve.
- busy_vec_o  out  NREGS  current scoreboard, unregistered view of the busy flops.

Behaviour:
- Reset
  - rst_i asserted asynchronously clears every register, every busy bit, rs_data_o and rs_busy_o to 0.
  - Release is synchronous to clk_i; the first valid read is issued on the first edge after release.
- Write
  - On posedge clk_i, for each w with rd_we_i[w]=1 and rd_addr_i[w]!=0: regs[addr] <= data.
  - Writes to address 0 are discarded; regs[0] reads 0 forever.
- Write conflict: several write ports targeting the same address in one cycle → the highest-index port wins.
- Read
  - Latency 1. If rs_re_i[p]=1 at edge N, rs_data_o[p] and rs_busy_o[p] show the addressed register from edge N onward.
  - If rs_re_i[p]=0, rs_data_o[p] and rs_busy_o[p] hold their previous values.
  - Address 0 always returns data 0 and busy 0.
- Scoreboard
  - rsv_we_i=1 with rsv_addr_i!=0 sets busy[rsv_addr_i] at the edge.
  - Any qualifying write (rd_we_i[w]=1, addr!=0) clears busy[addr] at the edge.
  - Reserve and write to the same address in the same cycle → busy ends 1 (reserve wins; it belongs to the younger instruction).
  - Reserve of address 0 is ignored.
- rs_busy_o sampling: uses the busy value after this cycle's reserve/clear updates; same resolution as the data bypass.
- Out-of-range addresses (NREGS not a power of two is illegal): unspecified.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read at edge N whose address matches a same-cycle write returns the new write data, taking the highest-index matching write port. rs_busy_o reflects the post-update scoreboard.
- Undefined: the read returns the pre-write register contents and the pre-update busy bit. Bench expectations switch on the same macro.

Decomposition:
- Package core_regfile_pkg:
  - default XLEN/NREGS constants;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef reg_data_t (logic [XLEN-1:0]);
  - function wr_resolve, returning the winning write data and hit flag for a given address across NWR ports.
- One sub-module, core_regfile_rdport: one read port's registered data and busy output plus its bypass mux. It is instantiated NRD times via generate.

Test Plan:
- Reset mid-operation: write x5=0xDEAD_BEEF, assert rst_i asynchronously between edges → rs_data_o=0 immediately; after release, a read of x5 returns 0x0000_0000.
- Write/read latency: write x7=0x1234_5678 at edge 1, read x7 on port 1 at edge 2 → rs_data_o[1]=0x1234_5678 after edge 2. A write to x0 of 0xFFFF_FFFF followed by a read of x0 → 0.
- Write conflict with NWR=2: port0 writes x3=0xAAAA_AAAA and port1 writes x3=0x5555_5555 in the same cycle → a later read returns 0x5555_5555.
- Bypass: write x9=0xCAFE_0001 and read x9 in the same cycle.
  - With REGFILE_BYPASS_EN → 0xCAFE_0001 on the next cycle.
  - Without it → the old value 0.
- Scoreboard:
  - Reserve x4 → busy_vec_o[4]=1.
  - Write x4 → busy_vec_o[4]=0.
  - Reserve and write x4 in the same cycle → busy_vec_o[4]=1.
  - Reserve x0 → busy_vec_o[0] stays 0.
- Read-enable hold: read x2=0x0000_0011 with rs_re_i[0]=1, then drop rs_re_i[0] and write x2=0x22 → rs_data_o[0] stays 0x11.

Source files
------------

// File: rtl/core_regfile_pkg.sv
// Shared types and helpers for the multi-port core register file.
// Holds the default sizing constants, the register address/data typedefs and
// the write-port resolver used by both the array update and the read bypass.
package core_regfile_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 32;
  localparam int unsigned DefAw    = $clog2(DefNregs);

  // The resolver works on a fixed maximum shape. Callers zero-extend their
  // ports into it, so unused slots must have their write enable cleared.
  localparam int unsigned MaxNwr  = 8;
  localparam int unsigned MaxAw   = 16;
  localparam int unsigned MaxXlen = 128;

  typedef logic [DefAw-1:0]   reg_addr_t;
  typedef logic [DefXlen-1:0] reg_data_t;

  typedef struct packed {
    logic               hit;
    logic [MaxXlen-1:0] data;
  } wr_res_t;

  // Winning write for one register address: the highest-index enabled port
  // that targets it. Address 0 never hits, so x0 stays zero.
  function automatic wr_res_t wr_resolve(
    input logic [MaxNwr-1:0]               we,
    input logic [MaxNwr-1:0][MaxAw-1:0]    addr,
    input logic [MaxNwr-1:0][MaxXlen-1:0]  data,
    input logic [MaxAw-1:0]                raddr
  );
    wr_res_t res;
    res = '0;
    for (int unsigned w = 0; w < MaxNwr; w++) begin
      if (we[w] && (addr[w] == raddr) && (raddr != '0)) begin
        res.hit  = 1'b1;
        res.data = data[w];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/core_regfile_rdport.sv
// One registered read port of core_regfile_mp.
// Captures the addressed register and its busy flag when re_i is high and
// holds otherwise. With REGFILE_BYPASS_EN defined, a same-cycle write to the
// read address is forwarded and busy reflects the post-update scoreboard;
// without it the port returns pre-write contents and the pre-update busy bit.
module core_regfile_rdport
  import core_regfile_pkg::*;
#(
  parameter int unsigned XLEN = DefXlen,
  parameter int unsigned AW   = DefAw
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            re_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            rf_busy_i,
  input  logic            byp_hit_i,
  input  logic [XLEN-1:0] byp_data_i,
  input  logic            busy_nxt_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o
);

  logic [XLEN-1:0] sel_data;
  logic            sel_busy;
  logic [XLEN-1:0] data_d, data_q;
  logic            busy_d, busy_q;
  logic            unused_sig;

`ifdef REGFILE_BYPASS_EN
  assign sel_data   = byp_hit_i ? byp_data_i : rf_data_i;
  assign sel_busy   = busy_nxt_i;
  assign unused_sig = rf_busy_i;
`else
  assign sel_data   = rf_data_i;
  assign sel_busy   = rf_busy_i;
  assign unused_sig = ^{byp_hit_i, byp_data_i, busy_nxt_i};
`endif

  // Next output value: x0 always reads as zero and never busy.
  always_comb begin
    data_d = sel_data;
    busy_d = sel_busy;
    if (addr_i == '0) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  // Output registers load only on an enabled read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else if (re_i) begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-port core register file with per-register busy scoreboard.
// NRD registered read ports, NWR write ports (highest index wins on a
// conflict), x0 hardwired to zero. Decode/issue reserves destination
// registers; writeback clears them. A same-cycle reserve beats the clear
// because it belongs to the younger instruction.
// Optional build macro: REGFILE_BYPASS_EN enables write-to-read forwarding.
module core_regfile_mp
  import core_regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = DefXlen,
  parameter  int unsigned NREGS = DefNregs,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NRD-1:0]       rs_re_i,
  input  logic [NRD*AW-1:0]    rs_addr_i,
  output logic [NRD*XLEN-1:0]  rs_data_o,
  output logic [NRD-1:0]       rs_busy_o,
  input  logic [NWR-1:0]       rd_we_i,
  input  logic [NWR*AW-1:0]    rd_addr_i,
  input  logic [NWR*XLEN-1:0]  rd_data_i,
  input  logic                 rsv_we_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic [NREGS-1:0]     busy_vec_o
);

  // Sizing must fit the package resolver: NWR <= MaxNwr, AW <= MaxAw,
  // XLEN <= MaxXlen.

  logic [XLEN-1:0]                regs_q [NREGS];
  logic [NREGS-1:0]               busy_q, busy_d;
  logic [NREGS-1:0]               wr_hit;
  logic [XLEN-1:0]                wr_dat [NREGS];
  logic [MaxNwr-1:0]              we_ext;
  logic [MaxNwr-1:0][MaxAw-1:0]   addr_ext;
  logic [MaxNwr-1:0][MaxXlen-1:0] data_ext;
  logic                           unused_res;

  // Widen the write ports into the resolver's fixed shape.
  always_comb begin
    we_ext   = '0;
    addr_ext = '0;
    data_ext = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      we_ext[w]   = rd_we_i[w];
      addr_ext[w] = MaxAw'(rd_addr_i[w*AW +: AW]);
      data_ext[w] = MaxXlen'(rd_data_i[w*XLEN +: XLEN]);
    end
  end

  // Per-register winning write; shared by the array update and the bypass.
  always_comb begin
    wr_res_t res;
    res        = '0;
    wr_hit     = '0;
    wr_dat     = '{default: '0};
    unused_res = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      res        = wr_resolve(we_ext, addr_ext, data_ext, MaxAw'(i));
      wr_hit[i]  = res.hit;
      wr_dat[i]  = res.data[XLEN-1:0];
      unused_res = unused_res ^ (^res);
    end
  end

  // Scoreboard next state: writeback clears, then reserve sets.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (rsv_we_i && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  // Architectural register array; x0 is never hit so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_hit[i]) begin
          regs_q[i] <= wr_dat[i];
        end
      end
    end
  end

  // Busy scoreboard flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rs_addr_i[p*AW +: AW];

    core_regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rdport (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .re_i       (rs_re_i[p]),
      .addr_i     (addr),
      .rf_data_i  (regs_q[addr]),
      .rf_busy_i  (busy_q[addr]),
      .byp_hit_i  (wr_hit[addr]),
      .byp_data_i (wr_dat[addr]),
      .busy_nxt_i (busy_d[addr]),
      .data_o     (rs_data_o[p*XLEN +: XLEN]),
      .busy_o     (rs_busy_o[p])
    );
  end

endmodule
